wdt_controller: RTL and testbench
=================================

WDT_CONTROLLER -- requirements
Module: wdt_controller

Interface
REQ-001 SHALL have parameter LOAD_RST, default 32'hFFFF_FFFF, reset value of LOAD.
REQ-002 SHALL have port clk  in  1  sole clock; all state on posedge clk.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high; driven from the system reset output (inverted).
REQ-004 SHALL have port addr  in  $clog2(`WDT_SIZE)  byte offset; `WDT_SIZE = 16.
REQ-005 SHALL have ports w_rb (in, 1, 1 = write), acc (in, `BUS_ACC_WIDTH), wdata (in, `BUS_WIDTH), req (in, 1).
REQ-006 SHALL have ports rdata (out, `BUS_WIDTH, registered), resp (out, 1), fault (out, 1, combinational).
REQ-007 SHALL have ports soc_fault (out, 1), soc_fault_cause (out, 8) and soc_fault_addr (out, `XLEN); these feed the reset controller.
REQ-008 SHALL have port irq  out  1  pre-timeout interrupt.

Function
REQ-009 Register map SHALL be: CTRL @0 2B RW (bit0 EN, bit1 LOCK); KICK @2 2B W; LOAD @4 4B RW; COUNT @8 4B R; TAG @12 4B RW.
REQ-010 fault SHALL be asserted as req & invld, where invld covers any of:
- unmapped address;
- acc not matching the register size;
- write to COUNT or read of KICK;
- write to CTRL or LOAD while LOCK=1.
REQ-011 A faulting access SHALL change no state.
REQ-012 resp SHALL be req & ~invld registered with 1-cycle latency; rdata SHALL be zero-extended and held between reads.
REQ-013 The FSM SHALL have three states: IDLE, RUN, EXPIRED.
REQ-014 In IDLE, a write that sets EN SHALL load COUNT <= LOAD and move to RUN.
REQ-015 In RUN, clearing EN SHALL return to IDLE with COUNT frozen.
REQ-016 In RUN, COUNT SHALL decrement by 1 per cycle; at COUNT == 0 the FSM SHALL enter EXPIRED.
REQ-017 Timeout SHALL therefore be exactly LOAD+1 cycles after the enabling write's resp cycle.
REQ-018 A KICK write of 16'hA5C3 in RUN SHALL reload COUNT <= LOAD.
REQ-019 A KICK write of any other value in RUN SHALL force EXPIRED on the next cycle.
REQ-020 A KICK write in IDLE SHALL be accepted and ignored.
REQ-021 If a valid kick and COUNT == 0 occur in the same cycle, the kick SHALL win.
REQ-022 On entry to EXPIRED: soc_fault SHALL be high for exactly 1 cycle, soc_fault_cause = `RST_CAUSE_WDT and soc_fault_addr = TAG.
REQ-023 The cause/addr outputs SHALL hold their values afterwards.
REQ-024 EXPIRED SHALL be exited only by rst; register writes SHALL still be accepted, but EN has no effect there.
REQ-025 LOCK SHALL be sticky-set: writing 0 is ignored, and LOCK is cleared only by rst.
REQ-026 LOAD = 0 SHALL give expiry 1 cycle after enable.
REQ-027 COUNT arithmetic SHALL be 32-bit unsigned and SHALL never wrap below 0.

Reset
REQ-028 While rst is high, the block SHALL hold the following values:
- state IDLE, EN 0, LOCK 0, COUNT 0, LOAD LOAD_RST, TAG 0;
- rdata 0, resp 0, soc_fault 0, soc_fault_cause 0, soc_fault_addr 0, irq 0.
REQ-029 An rst asserted mid-countdown SHALL abort immediately with no soc_fault pulse.

Configuration
REQ-030 With `WDT_IRQ_EN defined, irq SHALL be registered high while in RUN with COUNT <= (LOAD>>1), cleared by a valid kick, EN=0, or leaving RUN.
REQ-031 Without `WDT_IRQ_EN, irq SHALL be tied 0 and no compare logic SHALL be synthesized.

Structure
REQ-032 `WDT_SIZE, `RST_CAUSE_WDT (8'h04), the kick magic 16'hA5C3 and the register offsets SHALL live in femto.vh.
REQ-033 The block SHALL be a single module; the FSM and counter SHALL be inline, with no sub-module.

Verification
REQ-034 Write LOAD=10, write CTRL=1, no kicks -> soc_fault pulses exactly 11 cycles after the CTRL resp; cause 8'h04; addr = TAG.
REQ-035 LOAD=10, EN, kick A5C3 every 8 cycles for 200 cycles -> soc_fault never asserts; COUNT reads stay in 3..10.
REQ-036 Running, kick with 16'h1234 -> soc_fault on the next cycle; write TAG=32'hDEADBEEF beforehand -> soc_fault_addr = 32'hDEADBEEF.
REQ-037 Set LOCK, then write CTRL=0 or LOAD -> fault=1 and resp=0, values unchanged.
REQ-038 1-byte read of LOAD, read of KICK, write of COUNT, and access at addr 6 -> fault=1 each time.
REQ-039 Mid-countdown, assert rst for 1 cycle -> all outputs 0, state IDLE, no soc_fault pulse.
REQ-040 With `WDT_IRQ_EN and LOAD=10 -> irq rises when COUNT=5 and falls on the following kick.

Source files
------------

// File: rtl/wdt_controller_pkg.sv
// Shared constants and types for the watchdog timer: bus geometry, register
// offsets, access-size encodings, reset cause code, kick magic and FSM states.
package wdt_controller_pkg;

    localparam int WDT_SIZE      = 16;
    localparam int ADDR_W        = $clog2(WDT_SIZE);
    localparam int BUS_WIDTH     = 32;
    localparam int BUS_ACC_WIDTH = 2;
    localparam int XLEN          = 32;

    localparam logic [7:0]  RST_CAUSE_WDT = 8'h04;
    localparam logic [15:0] KICK_MAGIC    = 16'hA5C3;

    localparam logic [ADDR_W-1:0] OFF_CTRL  = 4'd0;
    localparam logic [ADDR_W-1:0] OFF_KICK  = 4'd2;
    localparam logic [ADDR_W-1:0] OFF_LOAD  = 4'd4;
    localparam logic [ADDR_W-1:0] OFF_COUNT = 4'd8;
    localparam logic [ADDR_W-1:0] OFF_TAG   = 4'd12;

    localparam logic [BUS_ACC_WIDTH-1:0] ACC_BYTE = 2'd0;
    localparam logic [BUS_ACC_WIDTH-1:0] ACC_HALF = 2'd1;
    localparam logic [BUS_ACC_WIDTH-1:0] ACC_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } wdt_state_e;

endpackage

// File: rtl/wdt_controller.sv
// Bus-mapped watchdog timer. Counts COUNT down from LOAD while enabled; a kick
// with the magic value reloads it, a bad kick or reaching zero expires the
// watchdog, pulsing soc_fault toward the reset controller with TAG as address.
// Optional feature: define WDT_IRQ_EN for the half-way pre-timeout interrupt.
module wdt_controller
    import wdt_controller_pkg::*;
#(
    parameter logic [31:0] LOAD_RST = 32'hFFFF_FFFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] acc,
    input  logic [BUS_WIDTH-1:0]     wdata,
    input  logic                     req,
    output logic [BUS_WIDTH-1:0]     rdata,
    output logic                     resp,
    output logic                     fault,
    output logic                     soc_fault,
    output logic [7:0]               soc_fault_cause,
    output logic [XLEN-1:0]          soc_fault_addr,
    output logic                     irq
);

    wdt_state_e           r_state;
    logic                 r_en;
    logic                 r_lock;
    logic [31:0]          r_count;
    logic [31:0]          r_load;
    logic [31:0]          r_tag;
    logic [BUS_WIDTH-1:0] r_rdata;
    logic                 r_resp;
    logic                 r_soc_fault;
    logic [7:0]           r_cause;
    logic [XLEN-1:0]      r_fault_addr;

    logic w_hit_ctrl, w_hit_kick, w_hit_load, w_hit_count, w_hit_tag;
    logic w_mapped, w_size_ok, w_invld, w_valid;
    logic w_wr_ctrl, w_wr_kick, w_wr_load, w_wr_tag, w_rd;
    logic w_start, w_disable, w_reload, w_bad_kick;
    logic [BUS_WIDTH-1:0] w_rd_mux;

    assign w_hit_ctrl  = (addr == OFF_CTRL);
    assign w_hit_kick  = (addr == OFF_KICK);
    assign w_hit_load  = (addr == OFF_LOAD);
    assign w_hit_count = (addr == OFF_COUNT);
    assign w_hit_tag   = (addr == OFF_TAG);
    assign w_mapped    = w_hit_ctrl | w_hit_kick | w_hit_load | w_hit_count | w_hit_tag;

    assign w_size_ok = ((w_hit_ctrl | w_hit_kick) && (acc == ACC_HALF)) ||
                       ((w_hit_load | w_hit_count | w_hit_tag) && (acc == ACC_WORD));

    assign w_invld = !w_mapped || !w_size_ok ||
                     (w_rb && w_hit_count) ||
                     (!w_rb && w_hit_kick) ||
                     (w_rb && r_lock && (w_hit_ctrl || w_hit_load));

    assign w_valid = req && !w_invld;
    assign fault   = req && w_invld;

    assign w_wr_ctrl = w_valid && w_rb && w_hit_ctrl;
    assign w_wr_kick = w_valid && w_rb && w_hit_kick;
    assign w_wr_load = w_valid && w_rb && w_hit_load;
    assign w_wr_tag  = w_valid && w_rb && w_hit_tag;
    assign w_rd      = w_valid && !w_rb;

    assign w_start    = w_wr_ctrl && wdata[0];
    assign w_disable  = w_wr_ctrl && !wdata[0];
    assign w_reload   = w_wr_kick && (wdata[15:0] == KICK_MAGIC);
    assign w_bad_kick = w_wr_kick && (wdata[15:0] != KICK_MAGIC);

    // Read data selection; values are zero-extended to the bus width.
    always_comb begin
        w_rd_mux = '0;
        if (w_hit_ctrl)
            w_rd_mux = {{(BUS_WIDTH-2){1'b0}}, r_lock, r_en};
        else if (w_hit_load)
            w_rd_mux = r_load;
        else if (w_hit_count)
            w_rd_mux = r_count;
        else if (w_hit_tag)
            w_rd_mux = r_tag;
    end

    // Bus response: resp one cycle after an accepted access, rdata held between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_resp <= w_valid;
            if (w_rd)
                r_rdata <= w_rd_mux;
        end
    end

    // Register file and watchdog FSM; a valid kick beats expiry at COUNT == 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_en         <= 1'b0;
            r_lock       <= 1'b0;
            r_count      <= '0;
            r_load       <= LOAD_RST;
            r_tag        <= '0;
            r_soc_fault  <= 1'b0;
            r_cause      <= '0;
            r_fault_addr <= '0;
        end else begin
            r_soc_fault <= 1'b0;
            if (w_wr_ctrl) begin
                r_en   <= wdata[0];
                r_lock <= r_lock | wdata[1];
            end
            if (w_wr_load)
                r_load <= wdata;
            if (w_wr_tag)
                r_tag <= wdata;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_count <= r_load;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_disable) begin
                        r_state <= ST_IDLE;
                    end else if (w_reload) begin
                        r_count <= r_load;
                    end else if (w_bad_kick || (r_count == 32'd0)) begin
                        r_state      <= ST_EXPIRED;
                        r_soc_fault  <= 1'b1;
                        r_cause      <= RST_CAUSE_WDT;
                        r_fault_addr <= r_tag;
                    end else begin
                        r_count <= r_count - 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rdata           = r_rdata;
    assign resp            = r_resp;
    assign soc_fault       = r_soc_fault;
    assign soc_fault_cause = r_cause;
    assign soc_fault_addr  = r_fault_addr;

`ifdef WDT_IRQ_EN
    logic r_irq;

    // Pre-timeout interrupt tracks the next COUNT value against half of LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_start) begin
            r_irq <= (r_load <= (r_load >> 1));
        end else if ((r_state == ST_RUN) && !w_disable && !w_wr_kick && (r_count != 32'd0)) begin
            r_irq <= ((r_count - 32'd1) <= (r_load >> 1));
        end else begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_wdt_controller.sv
// Directed self-checking bench for wdt_controller: a register-access vector
// table followed by hand-written countdown, kick, lock and reset sequences.
module tb_wdt_controller;

    localparam logic [1:0] AB = 2'd0;
    localparam logic [1:0] AH = 2'd1;
    localparam logic [1:0] AW = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  addr = '0;
    logic        w_rb = 1'b0;
    logic [1:0]  acc = '0;
    logic [31:0] wdata = '0;
    logic        req = 1'b0;
    logic [31:0] rdata;
    logic        resp;
    logic        fault;
    logic        soc_fault;
    logic [7:0]  soc_fault_cause;
    logic [31:0] soc_fault_addr;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic        lastFault;
    logic        lastResp;
    logic [31:0] lastRdata;
    logic        lastSocFault;
    logic        lastIrq;
    logic        sawSoc;

    typedef struct {
        logic        wrb;
        logic [1:0]  acc;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        expFault;
        logic        expResp;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[14];

    wdt_controller dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .w_rb           (w_rb),
        .acc            (acc),
        .wdata          (wdata),
        .req            (req),
        .rdata          (rdata),
        .resp           (resp),
        .fault          (fault),
        .soc_fault      (soc_fault),
        .soc_fault_cause(soc_fault_cause),
        .soc_fault_addr (soc_fault_addr),
        .irq            (irq)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One bus access, started at a negedge; returns at the following negedge.
    task automatic applyStimulus(input logic wrb, input logic [1:0] a, input logic [3:0] ad, input logic [31:0] d);
        req   = 1'b1;
        w_rb  = wrb;
        acc   = a;
        addr  = ad;
        wdata = d;
        #1;
        lastFault = fault;
        @(posedge clk);
        #1;
        lastResp     = resp;
        lastRdata    = rdata;
        lastSocFault = soc_fault;
        lastIrq      = irq;
        if (soc_fault) sawSoc = 1'b1;
        req   = 1'b0;
        w_rb  = 1'b0;
        wdata = '0;
        @(negedge clk);
    endtask

    task automatic tickIdle(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            if (soc_fault) sawSoc = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic waitForSocFault(input int limit, output int cycles);
        cycles = -1;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk);
            #1;
            if (soc_fault) begin
                cycles = c;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_rdata"}, rdata, 32'h0);
        checkOutput({tag, "_resp"}, 32'(resp), 32'h0);
        checkOutput({tag, "_soc_fault"}, 32'(soc_fault), 32'h0);
        checkOutput({tag, "_cause"}, 32'(soc_fault_cause), 32'h0);
        checkOutput({tag, "_addr"}, soc_fault_addr, 32'h0);
        checkOutput({tag, "_irq"}, 32'(irq), 32'h0);
    endtask

    task automatic doReset(input string tag);
        rst = 1'b1;
        #1;
        checkReset(tag);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int k;
        logic sawIrq;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkReset("por");
        rst = 1'b0;
        @(negedge clk);

        // wrb, acc, addr, wdata, expFault, expResp, expRdata (held value)
        vecs[0]  = '{1'b0, AH, 4'd0,  32'h0,        1'b0, 1'b1, 32'h0000_0000};
        vecs[1]  = '{1'b0, AW, 4'd4,  32'h0,        1'b0, 1'b1, 32'hFFFF_FFFF};
        vecs[2]  = '{1'b1, AW, 4'd12, 32'h1234_5678, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vecs[3]  = '{1'b0, AW, 4'd12, 32'h0,        1'b0, 1'b1, 32'h1234_5678};
        vecs[4]  = '{1'b0, AB, 4'd4,  32'h0,        1'b1, 1'b0, 32'h1234_5678};
        vecs[5]  = '{1'b0, AH, 4'd2,  32'h0,        1'b1, 1'b0, 32'h1234_5678};
        vecs[6]  = '{1'b1, AW, 4'd8,  32'h55,       1'b1, 1'b0, 32'h1234_5678};
        vecs[7]  = '{1'b0, AW, 4'd6,  32'h0,        1'b1, 1'b0, 32'h1234_5678};
        vecs[8]  = '{1'b0, AW, 4'd0,  32'h0,        1'b1, 1'b0, 32'h1234_5678};
        vecs[9]  = '{1'b1, AW, 4'd4,  32'h0000_000A, 1'b0, 1'b1, 32'h1234_5678};
        vecs[10] = '{1'b0, AW, 4'd4,  32'h0,        1'b0, 1'b1, 32'h0000_000A};
        vecs[11] = '{1'b0, AW, 4'd8,  32'h0,        1'b0, 1'b1, 32'h0000_0000};
        vecs[12] = '{1'b1, AH, 4'd2,  32'h0000_A5C3, 1'b0, 1'b1, 32'h0000_0000};
        vecs[13] = '{1'b0, AW, 4'd8,  32'h0,        1'b0, 1'b1, 32'h0000_0000};

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].wrb, vecs[i].acc, vecs[i].addr, vecs[i].wdata);
            checkOutput($sformatf("vec%0d_fault", i), 32'(lastFault), 32'(vecs[i].expFault));
            checkOutput($sformatf("vec%0d_resp", i), 32'(lastResp), 32'(vecs[i].expResp));
            checkOutput($sformatf("vec%0d_rdata", i), lastRdata, vecs[i].expRdata);
        end

        // Unkicked countdown with LOAD=10: expiry 11 cycles after the CTRL resp.
        applyStimulus(1'b1, AW, 4'd12, 32'hCAFE_0001);
        applyStimulus(1'b1, AH, 4'd0, 32'h1);
        checkOutput("en_resp", 32'(lastResp), 32'h1);
        checkOutput("en_no_soc", 32'(lastSocFault), 32'h0);
        waitForSocFault(40, k);
        checkOutput("expire_latency", 32'(k), 32'd11);
        checkOutput("expire_cause", 32'(soc_fault_cause), 32'h04);
        checkOutput("expire_addr", soc_fault_addr, 32'hCAFE_0001);
        @(posedge clk);
        #1;
        checkOutput("expire_pulse_width", 32'(soc_fault), 32'h0);
        checkOutput("expire_cause_hold", 32'(soc_fault_cause), 32'h04);
        checkOutput("expire_addr_hold", soc_fault_addr, 32'hCAFE_0001);
        @(negedge clk);
        sawSoc = 1'b0;
        applyStimulus(1'b1, AH, 4'd0, 32'h1);
        checkOutput("expired_wr_resp", 32'(lastResp), 32'h1);
        applyStimulus(1'b0, AW, 4'd8, 32'h0);
        checkOutput("expired_count", lastRdata, 32'h0);
        tickIdle(5);
        checkOutput("expired_no_repulse", 32'(sawSoc), 32'h0);
        doReset("rst1");

        // Regular kicks every 8 cycles keep the watchdog alive.
        applyStimulus(1'b1, AW, 4'd4, 32'd10);
        applyStimulus(1'b1, AH, 4'd0, 32'h1);
        sawSoc = 1'b0;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(1'b1, AH, 4'd2, 32'h0000_A5C3);
            for (int j = 1; j <= 7; j++) begin
                if (j == (i % 7) + 1) begin
                    applyStimulus(1'b0, AW, 4'd8, 32'h0);
                    checkOutput($sformatf("kick_count_%0d", i), lastRdata, 32'(11 - j));
                end else begin
                    tickIdle(1);
                end
            end
        end
        checkOutput("kick_no_soc", 32'(sawSoc), 32'h0);

        // Bad kick value expires on the next cycle with TAG as address.
        applyStimulus(1'b1, AW, 4'd12, 32'hDEAD_BEEF);
        applyStimulus(1'b1, AH, 4'd2, 32'h0000_1234);
        checkOutput("badkick_soc", 32'(lastSocFault), 32'h1);
        checkOutput("badkick_addr", soc_fault_addr, 32'hDEAD_BEEF);
        checkOutput("badkick_cause", 32'(soc_fault_cause), 32'h04);
        @(posedge clk);
        #1;
        checkOutput("badkick_pulse_width", 32'(soc_fault), 32'h0);
        @(negedge clk);
        doReset("rst2");

        // Kick coinciding with COUNT == 0 reloads instead of expiring.
        applyStimulus(1'b1, AW, 4'd4, 32'd3);
        applyStimulus(1'b1, AH, 4'd0, 32'h1);
        sawSoc = 1'b0;
        tickIdle(3);
        applyStimulus(1'b1, AH, 4'd2, 32'h0000_A5C3);
        applyStimulus(1'b0, AW, 4'd8, 32'h0);
        checkOutput("kick_at_zero_count", lastRdata, 32'd3);
        checkOutput("kick_at_zero_no_soc", 32'(sawSoc), 32'h0);
        applyStimulus(1'b1, AH, 4'd0, 32'h0);
        applyStimulus(1'b0, AW, 4'd8, 32'h0);
        checkOutput("disable_count", lastRdata, 32'd2);
        tickIdle(3);
        applyStimulus(1'b0, AW, 4'd8, 32'h0);
        checkOutput("disable_count_frozen", lastRdata, 32'd2);
        checkOutput("disable_no_soc", 32'(sawSoc), 32'h0);

        // LOAD=0 expires one cycle after the enabling resp.
        applyStimulus(1'b1, AW, 4'd4, 32'd0);
        applyStimulus(1'b1, AH, 4'd0, 32'h1);
        waitForSocFault(10, k);
        checkOutput("load0_latency", 32'(k), 32'd1);
        doReset("rst3");

        // LOCK blocks CTRL and LOAD writes.
        applyStimulus(1'b1, AW, 4'd4, 32'd20);
        applyStimulus(1'b1, AH, 4'd0, 32'h3);
        applyStimulus(1'b1, AH, 4'd0, 32'h0);
        checkOutput("lock_ctrl_fault", 32'(lastFault), 32'h1);
        checkOutput("lock_ctrl_resp", 32'(lastResp), 32'h0);
        applyStimulus(1'b1, AW, 4'd4, 32'd5);
        checkOutput("lock_load_fault", 32'(lastFault), 32'h1);
        checkOutput("lock_load_resp", 32'(lastResp), 32'h0);
        applyStimulus(1'b0, AH, 4'd0, 32'h0);
        checkOutput("lock_ctrl_value", lastRdata, 32'h3);
        applyStimulus(1'b0, AW, 4'd4, 32'h0);
        checkOutput("lock_load_value", lastRdata, 32'd20);

        // Reset mid-countdown aborts silently and clears LOCK.
        sawSoc = 1'b0;
        doReset("midrst");
        tickIdle(30);
        checkOutput("midrst_no_soc", 32'(sawSoc), 32'h0);
        applyStimulus(1'b0, AH, 4'd0, 32'h0);
        checkOutput("midrst_ctrl", lastRdata, 32'h0);
        applyStimulus(1'b0, AW, 4'd8, 32'h0);
        checkOutput("midrst_count", lastRdata, 32'h0);
        applyStimulus(1'b0, AW, 4'd4, 32'h0);
        checkOutput("midrst_load", lastRdata, 32'hFFFF_FFFF);

        // Pre-timeout interrupt behaviour with LOAD=10.
        applyStimulus(1'b1, AW, 4'd4, 32'd10);
        applyStimulus(1'b1, AH, 4'd0, 32'h1);
        checkOutput("irq_at_enable", 32'(lastIrq), 32'h0);
`ifdef WDT_IRQ_EN
        k = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (irq) begin
                k = c;
                break;
            end
        end
        @(negedge clk);
        checkOutput("irq_rise_cycle", 32'(k), 32'd5);
        applyStimulus(1'b1, AH, 4'd2, 32'h0000_A5C3);
        checkOutput("irq_cleared_by_kick", 32'(lastIrq), 32'h0);
`else
        sawIrq = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            #1;
            if (irq) sawIrq = 1'b1;
        end
        @(negedge clk);
        checkOutput("irq_tied_low", 32'(sawIrq), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
